gf2m_reduce_233: RTL and testbench

Sequential modular-reduction stage for GF(2^233) arithmetic. It sits directly downstream of the 233x233 three-way Toom-Cook carry-less multiplier. It takes that multiplier's 466-bit unreduced polynomial product and reduces it modulo the NIST B-233/K-233 trinomial x^233 + x^74 + 1. The result is a 233-bit field element, delivered under a valid/ready handshake in a fixed, data-independent number of cycles.

---
 rtl/gf2m_reduce_233.sv | 85 ++++++++
 tb/tb_gf2m_reduce_233.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gf2m_reduce_233.sv
// Two-fold sequential reduction of a 2M-bit carry-less product modulo x^M + x^K + 1.
// Define GF233_REDUCE_FAST_EN to merge both folds into one cycle.
module gf2m_reduce_233 #(
   parameter int M = 233,
   parameter int K = 74
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [2*M-1:0] c_in,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [M-1:0]   r
);

   // state | meaning
   // IDLE  | empty, accepting a product
   // F1    | first fold (both folds when the fast build is selected)
   // F2    | second fold, result fully reduced afterwards
   // DONE  | result presented on r, waiting for out_ready
   typedef enum logic [1:0] {IDLE, F1, F2, DONE} state_t;

   state_t         state;
   logic [2*M-1:0] acc;

   // x^M == x^K + 1, so the upper half folds back in at offsets 0 and K.
   function automatic logic [2*M-1:0] fold(input logic [2*M-1:0] a);
      logic [2*M-1:0] h;
      h = {{M{1'b0}}, a[2*M-1:M]};
      return {{M{1'b0}}, a[M-1:0]} ^ h ^ (h << K);
   endfunction

   assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
   assign r        = acc[M-1:0];

   // Both folds always run so that latency never depends on the data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         acc       <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  acc   <= c_in;
                  state <= F1;
               end
            end
            F1: begin
`ifdef GF233_REDUCE_FAST_EN
               acc       <= fold(fold(acc));
               state     <= DONE;
               out_valid <= 1'b1;
`else
               acc   <= fold(acc);
               state <= F2;
`endif
            end
            F2: begin
               acc       <= fold(acc);
               state     <= DONE;
               out_valid <= 1'b1;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (in_valid) begin
                     acc   <= c_in;
                     state <= F1;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gf2m_reduce_233.sv
// Bench for gf2m_reduce_233: bit-serial polynomial-division reference model, handshake
// timing model, directed literal vectors, random streaming and async reset aborts.
module tb_gf2m_reduce_233;

   localparam int M = 233;
   localparam int K = 74;
`ifdef GF233_REDUCE_FAST_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 3;
`endif

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [2*M-1:0] c_in = '0;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic [M-1:0]   r;

   // Literal expectation travelling alongside the current input vector.
   bit             lit_en = 1'b0;
   logic [M-1:0]   lit_val = '0;
   bit             mon_en = 1'b0;
   bit             rand_rdy = 1'b0;

   int nvec = 0;
   int nerr = 0;

   gf2m_reduce_233 #(.M(M), .K(K)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .c_in      (c_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .r         (r)
   );

   always #5 clk = ~clk;

   // Long division: clear each set coefficient above x^(M-1) using x^i = x^(i-M+K) + x^(i-M).
   function automatic logic [M-1:0] ref_mod(input logic [2*M-1:0] c);
      logic [2*M-1:0] t;
      t = c;
      for (int i = 2*M-1; i >= M; i--) begin
         if (t[i]) begin
            t[i]       = 1'b0;
            t[i-M+K]   = ~t[i-M+K];
            t[i-M]     = ~t[i-M];
         end
      end
      return t[M-1:0];
   endfunction

   function automatic logic [2*M-1:0] clmul(input logic [M-1:0] a, input logic [M-1:0] b);
      logic [2*M-1:0] res;
      logic [2*M-1:0] aa;
      res = '0;
      aa  = {{M{1'b0}}, a};
      for (int i = 0; i < M; i++)
         if (b[i]) res = res ^ (aa << i);
      return res;
   endfunction

   function automatic logic [2*M-1:0] rand_wide();
      logic [2*M-1:0] v;
      v = '0;
      for (int j = 0; j < 15; j++) v = {v[2*M-33:0], 32'($urandom)};
      return v;
   endfunction

   typedef struct {
      logic [M-1:0] exp;
      bit           le;
      logic [M-1:0] lit;
   } item_t;

   item_t q[$];
   bit    pend = 1'b0;
   int    cnt  = 0;
   bit    eov, eir;

   task automatic chk1(input string nm, input logic got, input logic exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s at %0t: got %b expected %b", nm, $time, got, exp);
      end
   endtask

   task automatic chk(input string nm, input logic [M-1:0] got, input logic [M-1:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, exp);
      end
   endtask

   // Single compare process: model timeline plus scoreboard of expected results.
   always @(negedge clk or posedge rst) begin
      if (mon_en) begin
         if (rst) begin
            if (clk) #1;
            chk1("rst_out_valid", out_valid, 1'b0);
            chk1("rst_in_ready", in_ready, 1'b1);
            chk("rst_r", r, '0);
            q.delete();
            pend = 1'b0;
            cnt  = 0;
         end else begin
            if (pend && cnt > 0) cnt--;
            eov = pend && (cnt == 0);
            eir = !pend || (eov && out_ready);
            chk1("out_valid", out_valid, eov);
            chk1("in_ready", in_ready, eir);
            if (eov && q.size() > 0) begin
               chk("r_model", r, q[0].exp);
               if (q[0].le) chk("r_literal", r, q[0].lit);
            end
            if (eov && out_ready) begin
               if (q.size() > 0) void'(q.pop_front());
               pend = 1'b0;
            end
            if (in_valid && eir) begin
               q.push_back('{ref_mod(c_in), lit_en, lit_val});
               pend = 1'b1;
               cnt  = LAT;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
   endtask

   // Holds c_in/in_valid until the handshake edge; returns 1 time unit after that edge.
   task automatic send(input logic [2*M-1:0] d, input bit le, input logic [M-1:0] lv);
      bit hs;
      int n;
      in_valid = 1'b1;
      c_in     = d;
      lit_en   = le;
      lit_val  = lv;
      n = 0;
      do begin
         @(negedge clk);
         hs = in_ready;
         tick();
         n++;
         if (n > 200) begin
            $display("FAIL send_timeout at %0t: in_ready never seen", $time);
            $fatal(1);
         end
      end while (!hs);
      in_valid = 1'b0;
      lit_en   = 1'b0;
   endtask

   task automatic wait_out_valid();
      int n;
      n = 0;
      while (!out_valid) begin
         tick();
         n++;
         if (n > 50) begin
            $display("FAIL out_valid_timeout at %0t: out_valid never seen", $time);
            $fatal(1);
         end
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() > 0) begin
         tick();
         n++;
         if (n > 500) begin
            $display("FAIL drain_timeout at %0t: %0d results outstanding", $time, q.size());
            $fatal(1);
         end
      end
      tick();
   endtask

   logic [2*M-1:0] d;
   logic [M-1:0]   e;

   initial begin
      tick();
      tick();
      mon_en = 1'b1;
      tick();
      @(posedge clk);
      #2 rst = 1'b0;
      #1 out_ready = 1'b1;

      // Directed vectors with hand-derived results.
      d = '0; d[0] = 1'b1;   e = '0; e[0] = 1'b1;
      send(d, 1'b1, e); drain();
      d = '0; d[233] = 1'b1; e = '0; e[74] = 1'b1; e[0] = 1'b1;
      send(d, 1'b1, e); drain();
      d = '0; d[465] = 1'b1; e = '0; e[232] = 1'b1; e[147] = 1'b1; e[73] = 1'b1;
      send(d, 1'b1, e); drain();
      d = '0; d[232] = 1'b1; e = '0; e[232] = 1'b1;
      send(d, 1'b1, e); drain();
      d = '0;                e = '0;
      send(d, 1'b1, e); drain();

      // Backpressure, then simultaneous drain and fill.
      out_ready = 1'b0;
      d = '0; d[0] = 1'b1; d[233] = 1'b1; e = '0; e[74] = 1'b1;
      send(d, 1'b1, e);
      wait_out_valid();
      repeat (10) tick();
      out_ready = 1'b1;
      d = '0; d[300] = 1'b1; e = '0; e[141] = 1'b1; e[67] = 1'b1;
      send(d, 1'b1, e);
      drain();

      // Random streaming with random valid gaps and random out_ready.
      rand_rdy = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         if (i % 2 == 0) d = rand_wide();
         else            d = clmul(M'(rand_wide()), M'(rand_wide()));
         send(d, 1'b0, '0);
         repeat ($urandom_range(0, 2)) tick();
      end
      drain();
      rand_rdy  = 1'b0;
      out_ready = 1'b1;

      // Abort during F1.
      d = rand_wide();
      send(d, 1'b0, '0);
      #1 rst = 1'b1;
      @(posedge clk);
      #2 rst = 1'b0;
      d = '0; d[465] = 1'b1; e = '0; e[232] = 1'b1; e[147] = 1'b1; e[73] = 1'b1;
      send(d, 1'b1, e); drain();

      // Abort while stalled in DONE.
      out_ready = 1'b0;
      send(rand_wide(), 1'b0, '0);
      wait_out_valid();
      #1 rst = 1'b1;
      @(posedge clk);
      #2 rst = 1'b0;
      #1 out_ready = 1'b1;
      d = '0; d[233] = 1'b1; e = '0; e[74] = 1'b1; e[0] = 1'b1;
      send(d, 1'b1, e); drain();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
